if_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the 5-stage RV32I pipeline. It issues word fetches to an instruction memory with one or more cycles of latency, and buffers responses in a small fetch queue. It hands {pc, instr} to decode over a valid/ready handshake. It replaces the fixed sequential PC+4/stall fetcher, adding configurable reset vector, taken-branch/jump redirect with in-flight kill, and back-pressure without losing fetched words.

---
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 tb/tb_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: credit-limited word fetches, in-order response queue, redirect with in-flight kill.
// Optional misaligned-redirect trap entry enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_instr,
  input  logic               id_ready
`ifdef IF_MISALIGN_TRAP_EN
  , output logic             if_misalign
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   fl_pc   [FQ_DEPTH];
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [PW-1:0] fl_rd, fl_wr, q_rd, q_wr;
  logic [CW-1:0] q_cnt, outstanding, drop_cnt;
  logic [CW:0]   credit_used;
  logic          pop, rsp, rsp_drop, q_push, issue, idle;

`ifdef IF_MISALIGN_TRAP_EN
  logic          q_mis [FQ_DEPTH];
  logic          trap_push;
  assign trap_push = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign idle = 1'b0;
`endif

  // Credit counts queued entries plus requests in flight, so a response always finds a free slot.
  always_comb begin
    pop         = if_valid && id_ready && !redirect_valid;
    rsp         = imem_rvalid && (outstanding != '0);
    rsp_drop    = rsp && (redirect_valid || (drop_cnt != '0));
    q_push      = rsp && !rsp_drop;
    credit_used = {1'b0, q_cnt} + {1'b0, outstanding} - {{CW{1'b0}}, if_valid && id_ready};
    issue       = !reset && !redirect_valid && !idle && (credit_used < DEPTH_W);
  end

  assign imem_req  = issue;
  assign imem_addr = issue ? fetch_pc[IMEM_AW+1:2] : '0;
  assign if_valid  = (q_cnt != '0);
  assign if_pc     = if_valid ? q_pc[q_rd] : '0;
  assign if_instr  = if_valid ? q_instr[q_rd] : '0;
`ifdef IF_MISALIGN_TRAP_EN
  assign if_misalign = if_valid ? q_mis[q_rd] : 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fl_rd       <= '0;
      fl_wr       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      idle        <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (redirect_valid) begin
        // Everything still in flight after this edge is stale and gets dropped on arrival.
        fl_rd    <= '0;
        fl_wr    <= '0;
        q_rd     <= '0;
        drop_cnt <= outstanding - CW'(rsp);
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_TRAP_EN
        idle     <= trap_push;
        q_wr     <= trap_push ? PW'(1) : '0;
        q_cnt    <= trap_push ? CW'(1) : '0;
`else
        q_wr     <= '0;
        q_cnt    <= '0;
`endif
      end else begin
        if (issue) begin
          fl_wr    <= fl_wr + PW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (q_push) begin
          q_wr  <= q_wr + PW'(1);
          fl_rd <= fl_rd + PW'(1);
        end
        if (pop) q_rd <= q_rd + PW'(1);
        q_cnt <= q_cnt + CW'(q_push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fl_pc[fl_wr] <= fetch_pc;
    if (q_push) begin
      q_pc[q_wr]    <= fl_pc[fl_rd];
      q_instr[q_wr] <= imem_rdata;
`ifdef IF_MISALIGN_TRAP_EN
      q_mis[q_wr]   <= 1'b0;
`endif
    end
`ifdef IF_MISALIGN_TRAP_EN
    if (trap_push) begin
      q_pc[0]    <= redirect_pc;
      q_instr[0] <= 32'h0000_0013;
      q_mis[0]   <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency in-order memory model, stream-level reference model, directed pins.
module tb_if_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        redirect_valid = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, if_valid;
  logic [7:0]  imem_addr;
  logic [31:0] if_pc, if_instr;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  if_fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH), .IMEM_AW(8)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready)
`ifdef IF_MISALIGN_TRAP_EN
    , .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_deliv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [7:0] a);
    return ({24'h0, a} * 32'h0019_660D) ^ 32'hC0DE_0000 ^ {a, 24'h0};
  endfunction

  // Memory model: in order, per-request latency lat, never reorders.
  typedef struct { logic [7:0] a; int unsigned due; } req_t;
  req_t        pend[$];
  int unsigned cyc = 0, lat = 1, last_due = 0;

  task automatic cycle_begin();
    @(posedge clk); #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend[0].a);
      void'(pend.pop_front());
    end
  endtask

  task automatic cycle_end();
    req_t r;
    @(negedge clk);
    if (imem_req) begin
      r.a   = imem_addr;
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      pend.push_back(r);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
    cycle_begin();
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rdy;
    cycle_end();
  endtask

  // Leaves the bench inside cycle 0 (first cycle with reset low), before its sampling point.
  task automatic apply_reset();
    reset = 1'b1;
    pend.delete();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    last_due = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // Reference model: expected delivered stream and fetch stream as plain PC sequences.
  logic [31:0] exp_pc, exp_fetch, trap_pc;
  logic        hold_prev, trap_mode, trap_entry;
  int          inflight, streak;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc = RPC; exp_fetch = RPC; trap_pc = '0;
      hold_prev = 1'b0; trap_mode = 1'b0; trap_entry = 1'b0;
      inflight = 0; streak = 0;
    end else begin
      if (redirect_valid) chk("req_on_redirect", 32'(imem_req), 32'd0);
      if (trap_mode) begin
        chk("trap_idle_req", 32'(imem_req), 32'd0);
        if (if_valid) begin
          chk("trap_single", 32'(trap_entry), 32'd1);
          chk("trap_pc", if_pc, trap_pc);
          chk("trap_instr", if_instr, 32'h0000_0013);
`ifdef IF_MISALIGN_TRAP_EN
          chk("trap_flag", 32'(if_misalign), 32'd1);
`endif
        end
        streak = 0;
      end else begin
        if (imem_req) begin
          chk("fetch_addr", 32'(imem_addr), 32'(exp_fetch[9:2]));
          exp_fetch = exp_fetch + 32'd4;
        end
        if (if_valid) begin
          chk("if_pc", if_pc, exp_pc);
          chk("if_instr", if_instr, memf(exp_pc[9:2]));
`ifdef IF_MISALIGN_TRAP_EN
          chk("misalign_flag", 32'(if_misalign), 32'd0);
`endif
        end
        streak = (if_valid || redirect_valid) ? 0 : streak + 1;
        chk("fill_gap", 32'(streak < 8), 32'd1);
      end
      if (hold_prev) chk("hold_valid", 32'(if_valid), 32'd1);
      if (imem_rvalid && inflight > 0) inflight--;
      if (imem_req) inflight++;
      chk("credit", 32'(inflight <= DEPTH), 32'd1);
      if (redirect_valid) begin
        if (TRAP_EN && redirect_pc[1:0] != 2'b00) begin
          trap_mode = 1'b1; trap_entry = 1'b1; trap_pc = redirect_pc;
        end else begin
          trap_mode = 1'b0;
          exp_pc    = redirect_pc & 32'hFFFF_FFFC;
          exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end
      end else if (if_valid && id_ready) begin
        n_deliv++;
        if (trap_mode) trap_entry = 1'b0;
        else exp_pc = exp_pc + 32'd4;
      end
      hold_prev = if_valid && !id_ready && !redirect_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rv, prev_rv;
    logic [31:0] rp;

    // Reset fill and steady stream, 1-cycle memory
    lat = 1;
    apply_reset();
    cycle_end();
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'h40);
    chk("c0_valid", 32'(if_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("c1_addr", 32'(imem_addr), 32'h41);
    chk("c1_valid", 32'(if_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("c2_valid", 32'(if_valid), 32'd1);
    chk("c2_pc", if_pc, 32'h100);
    chk("c2_instr", if_instr, memf(8'h40));
    chk("c2_addr", 32'(imem_addr), 32'h42);
    step(1'b0, '0, 1'b1);
    chk("c3_pc", if_pc, 32'h104);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Back-pressure for 5 cycles
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_pc", if_pc, 32'h110);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("resume_pc0", if_pc, 32'h110);
    step(1'b0, '0, 1'b1);
    chk("resume_pc1", if_pc, 32'h114);
    step(1'b0, '0, 1'b1);

    // Redirect latency
    step(1'b1, 32'h200, 1'b1);
    chk("redir_req", 32'(imem_req), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("redir_t1_valid", 32'(if_valid), 32'd0);
    chk("redir_t1_addr", 32'(imem_addr), 32'h80);
    step(1'b0, '0, 1'b1);
    chk("redir_t2_valid", 32'(if_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("redir_t3_pc", if_pc, 32'h200);
    chk("redir_t3_instr", if_instr, memf(8'h80));

    // Back-to-back redirect: second one wins
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h400, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("b2b_addr", 32'(imem_addr), 32'h00);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("b2b_pc", if_pc, 32'h400);

    // Asynchronous reset while the queue is full
    repeat (4) step(1'b0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    apply_reset();
    cycle_end();
    chk("rst_c0_addr", 32'(imem_addr), 32'h40);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rst_c2_pc", if_pc, 32'h100);

    // Randomised traffic over several memory latencies
    for (int unsigned l = 1; l <= 3; l++) begin
      lat = l;
      apply_reset();
      cycle_end();
      prev_rv = 1'b0;
      for (int i = 0; i < 400; i++) begin
        rv = prev_rv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h0000_0FFF);
        step(rv, rp, $urandom_range(0, 3) != 0);
        prev_rv = rv;
      end
    end
    repeat (10) step(1'b0, '0, 1'b1);
    chk("progress", 32'(n_deliv > 150), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
